// File: rtl/ceyloniac_regfile_mp_if.sv
// rtl/ceyloniac_regfile_mp_if.sv - read/write bus bundle for the multi-port register file
interface ceyloniac_regfile_mp_if #(
    parameter int REG_DATA_WIDTH = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_READ_PORTS = 2
);
    logic [NUM_READ_PORTS*REG_ADDR_WIDTH-1:0] read_addr;
    logic [NUM_READ_PORTS*REG_DATA_WIDTH-1:0] read_data;
    logic                                     write_enable0;
    logic                                     write_enable1;
    logic [REG_ADDR_WIDTH-1:0]                write_addr0;
    logic [REG_ADDR_WIDTH-1:0]                write_addr1;
    logic [REG_DATA_WIDTH-1:0]                write_data0;
    logic [REG_DATA_WIDTH-1:0]                write_data1;
    logic                                     ready;
    logic                                     write_collision;

    modport master (
        output read_addr, write_enable0, write_enable1,
        output write_addr0, write_addr1, write_data0, write_data1,
        input  read_data, ready, write_collision
    );

    modport slave (
        input  read_addr, write_enable0, write_enable1,
        input  write_addr0, write_addr1, write_data0, write_data1,
        output read_data, ready, write_collision
    );
endinterface

// File: rtl/ceyloniac_regfile_mp.sv
// rtl/ceyloniac_regfile_mp.sv - multi-port register file with dual write ports and clear engine
module ceyloniac_regfile_mp #(
    parameter int REG_DATA_WIDTH = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int NUM_READ_PORTS = 2,
    parameter int BYPASS         = 1,
    parameter int ZERO_REG       = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    ceyloniac_regfile_mp_if.slave   bus
);
    localparam int DW    = REG_DATA_WIDTH;
    localparam int AW    = REG_ADDR_WIDTH;
    localparam int DEPTH = 1 << AW;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t          state_q, state_d;
    logic [AW:0]     clr_addr_q, clr_addr_d;
    logic            ready_q, ready_d;
    logic            collision_q, collision_d;
    logic [DW-1:0]   mem_q [DEPTH];
    logic [DW-1:0]   mem_d [DEPTH];
    logic            wr0_ok, wr1_ok;
    logic [NUM_READ_PORTS*DW-1:0] rdata;
    logic [AW-1:0]   raddr;

    // Control state; the array itself is deliberately not reset, the clear engine zeroes it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_CLEAR;
            clr_addr_q  <= '0;
            ready_q     <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            ready_q     <= ready_d;
            collision_q <= collision_d;
        end
    end

    // Storage array update.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Next state: sequential clear of one entry per edge, then normal dual-port writes.
    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        ready_d     = ready_q;
        collision_d = 1'b0;
        mem_d       = mem_q;
        // Writes to entry 0 are dropped when it is hardwired, but still count as collisions.
        wr0_ok      = bus.write_enable0 && !((ZERO_REG != 0) && (bus.write_addr0 == '0));
        wr1_ok      = bus.write_enable1 && !((ZERO_REG != 0) && (bus.write_addr1 == '0));
        case (state_q)
            ST_CLEAR: begin
                mem_d[clr_addr_q[AW-1:0]] = '0;
                clr_addr_d = clr_addr_q + 1'b1;
                // Carry into the top bit means entry DEPTH-1 was cleared on this edge.
                if (clr_addr_d[AW]) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end
            end
            ST_RUN: begin
                // Port 1 is applied last so it wins a same-address collision.
                if (wr0_ok) mem_d[bus.write_addr0] = bus.write_data0;
                if (wr1_ok) mem_d[bus.write_addr1] = bus.write_data1;
                collision_d = bus.write_enable0 && bus.write_enable1 &&
                              (bus.write_addr0 == bus.write_addr1);
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // Combinational read ports with optional same-cycle forwarding (port 1 over port 0).
    always_comb begin
        rdata = '0;
        raddr = '0;
        for (int k = 0; k < NUM_READ_PORTS; k++) begin
            raddr = bus.read_addr[k*AW +: AW];
            if (state_q != ST_RUN || ((ZERO_REG != 0) && raddr == '0)) begin
                rdata[k*DW +: DW] = '0;
            end else if ((BYPASS != 0) && bus.write_enable1 && bus.write_addr1 == raddr) begin
                rdata[k*DW +: DW] = bus.write_data1;
            end else if ((BYPASS != 0) && bus.write_enable0 && bus.write_addr0 == raddr) begin
                rdata[k*DW +: DW] = bus.write_data0;
            end else begin
                rdata[k*DW +: DW] = mem_q[raddr];
            end
        end
    end

    assign bus.read_data       = rdata;
    assign bus.ready           = ready_q;
    assign bus.write_collision = collision_q;
endmodule

// File: tb/tb_ceyloniac_regfile_mp.sv
// tb/tb_ceyloniac_regfile_mp.sv - self-checking bench for the multi-port register file
module tb_ceyloniac_regfile_mp;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ceyloniac_regfile_mp_if #(.REG_DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .NUM_READ_PORTS(NR)) bus_a ();
    ceyloniac_regfile_mp_if #(.REG_DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .NUM_READ_PORTS(NR)) bus_b ();

    logic          we0, we1;
    logic [AW-1:0] wa0, wa1;
    logic [DW-1:0] wd0, wd1;
    logic [AW-1:0] ra [NR];

    assign bus_a.write_enable0 = we0;  assign bus_b.write_enable0 = we0;
    assign bus_a.write_enable1 = we1;  assign bus_b.write_enable1 = we1;
    assign bus_a.write_addr0   = wa0;  assign bus_b.write_addr0   = wa0;
    assign bus_a.write_addr1   = wa1;  assign bus_b.write_addr1   = wa1;
    assign bus_a.write_data0   = wd0;  assign bus_b.write_data0   = wd0;
    assign bus_a.write_data1   = wd1;  assign bus_b.write_data1   = wd1;
    assign bus_a.read_addr     = {ra[1], ra[0]};
    assign bus_b.read_addr     = {ra[1], ra[0]};

    ceyloniac_regfile_mp #(.REG_DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .NUM_READ_PORTS(NR),
                           .BYPASS(1), .ZERO_REG(1))
        dut_a (.clk(clk), .reset_n(rst_n), .bus(bus_a));
    ceyloniac_regfile_mp #(.REG_DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .NUM_READ_PORTS(NR),
                           .BYPASS(0), .ZERO_REG(1))
        dut_b (.clk(clk), .reset_n(rst_n), .bus(bus_b));

    int errors = 0;
    int checks = 0;

    // Reference model: plain array plus an edge count since reset.
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_ready;
    int            m_edges;
    bit            m_coll;

    function automatic void model_reset();
        foreach (m_mem[i]) m_mem[i] = '0;
        m_ready = 1'b0;
        m_edges = 0;
        m_coll  = 1'b0;
    endfunction

    function automatic void model_edge();
        if (!m_ready) begin
            m_coll  = 1'b0;
            m_edges = m_edges + 1;
            if (m_edges == DEPTH) m_ready = 1'b1;
        end else begin
            m_coll = we0 && we1 && (wa0 == wa1);
            if (we0 && wa0 != 0) m_mem[wa0] = wd0;
            if (we1 && wa1 != 0) m_mem[wa1] = wd1;
        end
    endfunction

    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a, input bit byp);
        if (!m_ready || a == 0) return '0;
        if (byp && we1 && wa1 == a) return wd1;
        if (byp && we0 && wa0 == a) return wd0;
        return m_mem[a];
    endfunction

    function automatic logic [DW-1:0] rd(input int d, input int k);
        if (d == 0) return bus_a.read_data[k*DW +: DW];
        return bus_b.read_data[k*DW +: DW];
    endfunction

    function automatic logic rdy(input int d);
        return (d == 0) ? bus_a.ready : bus_b.ready;
    endfunction

    function automatic logic col(input int d);
        return (d == 0) ? bus_a.write_collision : bus_b.write_collision;
    endfunction

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0;
        wa0 = AW'($urandom); wa1 = AW'($urandom);
        wd0 = $urandom; wd1 = $urandom;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        idle();
        ra[0] = 5'd3; ra[1] = 5'd17;
        #3;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rdy(d) !== 1'b0 || col(d) !== 1'b0) begin
                errors++; $display("FAIL reset_flags dut%0d ready=%b coll=%b want 0 0", d, rdy(d), col(d));
            end
            for (int k = 0; k < NR; k++) begin
                checks++;
                if (rd(d, k) !== exp_read(ra[k], d == 0)) begin
                    errors++; $display("FAIL reset_read dut%0d port%0d got=%h want=%h", d, k, rd(d, k), exp_read(ra[k], d == 0));
                end
            end
        end
        #19 rst_n = 1'b1;
        for (int e = 1; e <= DEPTH; e++) begin
            we0 = 1'($urandom); we1 = 1'($urandom);
            wa0 = AW'($urandom); wa1 = AW'($urandom);
            wd0 = $urandom; wd1 = $urandom;
            ra[0] = wa0; ra[1] = AW'($urandom);
            #1;
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < NR; k++) begin
                    checks++;
                    if (rd(d, k) !== 32'h0) begin
                        errors++; $display("FAIL clear_read edge%0d dut%0d port%0d got=%h want=0", e, d, k, rd(d, k));
                    end
                end
            end
            tick();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (rdy(d) !== (e == DEPTH) || col(d) !== 1'b0) begin
                    errors++; $display("FAIL clear_ready edge%0d dut%0d ready=%b coll=%b want %b 0", e, d, rdy(d), col(d), e == DEPTH);
                end
            end
        end
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            ra[0] = AW'(i); ra[1] = AW'(DEPTH - 1 - i);
            #1;
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < NR; k++) begin
                    checks++;
                    if (rd(d, k) !== 32'h0) begin
                        errors++; $display("FAIL cleared_contents addr%0d dut%0d got=%h want=0", ra[k], d, rd(d, k));
                    end
                end
            end
        end
    endtask

    task automatic test_dual_write();
        @(negedge clk);
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h11111111;
        we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h22222222;
        tick();
        idle();
        ra[0] = 5'd5; ra[1] = 5'd9;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rd(d, 0) !== 32'h11111111 || rd(d, 1) !== 32'h22222222) begin
                errors++; $display("FAIL dual_write dut%0d r5=%h r9=%h want 11111111 22222222", d, rd(d, 0), rd(d, 1));
            end
            checks++;
            if (col(d) !== 1'b0) begin
                errors++; $display("FAIL dual_write_coll dut%0d got=%b want=0", d, col(d));
            end
        end
    endtask

    task automatic test_collision();
        @(negedge clk);
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'hAAAA0000;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h0000BBBB;
        tick();
        idle();
        ra[0] = 5'd7; ra[1] = 5'd7;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (col(d) !== 1'b1) begin
                errors++; $display("FAIL collision_pulse dut%0d got=%b want=1", d, col(d));
            end
            checks++;
            if (rd(d, 0) !== 32'h0000BBBB) begin
                errors++; $display("FAIL collision_data dut%0d got=%h want=0000bbbb", d, rd(d, 0));
            end
        end
        tick();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (col(d) !== 1'b0) begin
                errors++; $display("FAIL collision_end dut%0d got=%b want=0", d, col(d));
            end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            we0 = 1'b1; we1 = 1'b1;
            wa0 = AW'(20 + i); wa1 = AW'(20 + i);
            wd0 = $urandom; wd1 = $urandom;
            tick();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (col(d) !== m_coll) begin
                    errors++; $display("FAIL b2b_coll step%0d dut%0d got=%b want=%b", i, d, col(d), m_coll);
                end
            end
        end
        idle();
        ra[0] = 5'd20; ra[1] = 5'd22;
        tick();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (col(d) !== 1'b0 || rd(d, 0) !== m_mem[20] || rd(d, 1) !== m_mem[22]) begin
                errors++; $display("FAIL b2b_after dut%0d coll=%b r20=%h r22=%h want 0 %h %h", d, col(d), rd(d, 0), rd(d, 1), m_mem[20], m_mem[22]);
            end
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        we0 = 1'b1; wa0 = 5'd12; wd0 = 32'h01010101;
        tick();
        idle();
        we0 = 1'b1; wa0 = 5'd12; wd0 = 32'hDEADBEEF;
        ra[0] = 5'd12; ra[1] = 5'd12;
        #1;
        checks++;
        if (rd(0, 0) !== 32'hDEADBEEF) begin
            errors++; $display("FAIL bypass_on_same got=%h want=deadbeef", rd(0, 0));
        end
        checks++;
        if (rd(1, 0) !== 32'h01010101) begin
            errors++; $display("FAIL bypass_off_same got=%h want=01010101", rd(1, 0));
        end
        tick();
        idle();
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rd(d, 1) !== 32'hDEADBEEF) begin
                errors++; $display("FAIL bypass_next dut%0d got=%h want=deadbeef", d, rd(d, 1));
            end
        end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        idle();
        we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFFFFFF;
        ra[0] = 5'd0; ra[1] = 5'd0;
        for (int pass = 0; pass < 2; pass++) begin
            #1;
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < NR; k++) begin
                    checks++;
                    if (rd(d, k) !== 32'h0) begin
                        errors++; $display("FAIL zero_reg pass%0d dut%0d port%0d got=%h want=0", pass, d, k, rd(d, k));
                    end
                end
            end
            tick();
            idle();
        end
    endtask

    task automatic test_random();
        @(negedge clk);
        for (int n = 0; n < 400; n++) begin
            we0 = 1'($urandom); we1 = 1'($urandom);
            wa0 = AW'($urandom);
            wa1 = ($urandom_range(0, 3) == 0) ? wa0 : AW'($urandom);
            wd0 = $urandom; wd1 = $urandom;
            for (int k = 0; k < NR; k++) begin
                case ($urandom_range(0, 3))
                    0: ra[k] = wa0;
                    1: ra[k] = wa1;
                    default: ra[k] = AW'($urandom);
                endcase
            end
            #1;
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < NR; k++) begin
                    checks++;
                    if (rd(d, k) !== exp_read(ra[k], d == 0)) begin
                        errors++; $display("FAIL random_read it%0d dut%0d port%0d addr=%0d got=%h want=%h", n, d, k, ra[k], rd(d, k), exp_read(ra[k], d == 0));
                    end
                end
            end
            tick();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (col(d) !== m_coll || rdy(d) !== m_ready) begin
                    errors++; $display("FAIL random_flags it%0d dut%0d coll=%b ready=%b want %b %b", n, d, col(d), rdy(d), m_coll, m_ready);
                end
            end
        end
        idle();
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h12345678;
        tick();
        idle();
        ra[0] = 5'd3; ra[1] = 5'd3;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rd(d, 0) !== 32'h12345678) begin
                errors++; $display("FAIL mid_reset_pre dut%0d got=%h want=12345678", d, rd(d, 0));
            end
        end
        rst_n = 1'b0;
        model_reset();
        #2;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rdy(d) !== 1'b0 || rd(d, 0) !== 32'h0) begin
                errors++; $display("FAIL mid_reset_asserted dut%0d ready=%b r3=%h want 0 0", d, rdy(d), rd(d, 0));
            end
        end
        #10 rst_n = 1'b1;
        for (int e = 1; e <= DEPTH; e++) begin
            if (e == 5 || e == DEPTH) begin
                we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hFFFF0000;
                we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h0000FFFF;
            end else begin
                idle();
            end
            tick();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (rdy(d) !== (e == DEPTH) || col(d) !== 1'b0) begin
                    errors++; $display("FAIL mid_reset_clear edge%0d dut%0d ready=%b coll=%b want %b 0", e, d, rdy(d), col(d), e == DEPTH);
                end
            end
        end
        idle();
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rd(d, 0) !== 32'h0) begin
                errors++; $display("FAIL mid_reset_cleared dut%0d r3=%h want=0", d, rd(d, 0));
            end
        end
        @(negedge clk);
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h5A5A5A5A;
        tick();
        idle();
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rd(d, 1) !== 32'h5A5A5A5A) begin
                errors++; $display("FAIL mid_reset_first_write dut%0d r3=%h want=5a5a5a5a", d, rd(d, 1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_dual_write();
        test_collision();
        test_back_to_back();
        test_bypass();
        test_zero_reg();
        test_random();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ceyloniac_regfile_mp.md
# ceyloniac_regfile_mp

Multi-port, parametrised register file for the ceyloniac core. It replaces the single-write/two-read register file in the decode/writeback path. It adds a configurable number of read ports, two write ports with defined collision priority, and optional same-cycle write-to-read bypass. It also adds hardware reset clearing through a sequential clear engine, so software never observes stale contents after reset.

## Interface
Parameters:
- REG_DATA_WIDTH, 32, width of each register.
- REG_ADDR_WIDTH, 5, address width; DEPTH = 1<<REG_ADDR_WIDTH entries.
- NUM_READ_PORTS, 2, number of read ports (1..8).
- BYPASS, 1, 1 = a read of an address being written this cycle returns the write data; 0 = it returns the old contents.
- ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes.

Ports:
- clk  in  1  single clock, rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- read_addr  in  NUM_READ_PORTS*REG_ADDR_WIDTH  packed read addresses; port k occupies bits [k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH].
- read_data  out  NUM_READ_PORTS*REG_DATA_WIDTH  packed read data, same packing.
- write_enable0 / write_enable1  in  1  write port 0/1 enables.
- write_addr0 / write_addr1  in  REG_ADDR_WIDTH  write addresses.
- write_data0 / write_data1  in  REG_DATA_WIDTH  write data.
- ready  out  1  high when the clear is complete and writes are accepted.
- write_collision  out  1  registered one-cycle pulse: both ports wrote the same address.

## Operation
- States: CLEAR and RUN. A clear counter clr_addr has REG_ADDR_WIDTH+1 bits.
- Reset asserted (asynchronous):
  - state=CLEAR, clr_addr=0, ready=0, write_collision=0.
  - Array contents are not reset directly.
- CLEAR:
  - Each rising edge with reset_n high writes 0 to entry clr_addr and increments clr_addr.
  - On the edge that clears entry DEPTH-1: state→RUN, ready→1.
  - write_enable0/1 are ignored, and write_collision stays 0.
  - All read_data ports output 0.
- RUN:
  - Port 0 writes when write_enable0=1; port 1 writes when write_enable1=1.
  - Both enabled with the same address: port 1's data is stored, and write_collision=1 on the next cycle.
  - Different addresses: both are stored in the same edge.
  - ZERO_REG=1: writes to address 0 are dropped. They are still counted for collision detection.
- Reads: combinational, asynchronous in the address.
  - read_data[k] = 0 if ZERO_REG=1 and address=0.
  - Otherwise, if BYPASS=1 and a write to that address is enabled this cycle, the forwarded data (port 1 over port 0).
  - Otherwise, the array contents.
- Reset during CLEAR or RUN: return immediately to CLEAR at clr_addr=0; the full clear restarts.
- No state is held on reads; the read_addr inputs carry no enable gating.

## Timing
- Reset values: ready=0, write_collision=0, read_data=all zeros.
- Clear latency: ready rises after exactly DEPTH rising edges following reset_n deassertion (32 edges at defaults).
- Write latency: data is stored at the rising edge.
  - BYPASS=0: a read in the next cycle returns the new value.
  - BYPASS=1: a read in the same cycle returns the new value.
- write_collision is high for exactly the one cycle following a colliding edge. Back-to-back collisions hold it high continuously.
- A write presented on the edge where ready rises is ignored; the first write accepted is on the edge after ready=1 is observed.

## Test plan
- Reset then clear: pulse reset_n low, release, and count edges → ready=0 for edges 1..31 and ready=1 after edge 32; every read_data returns 0 throughout; afterwards all 32 addresses read 0x00000000.
- Dual write, distinct addresses: write0 0x11111111→r5 and write1 0x22222222→r9 in one cycle → next cycle r5=0x11111111, r9=0x22222222, write_collision=0.
- Collision: write0 0xAAAA0000→r7 and write1 0x0000BBBB→r7 in one cycle → r7=0x0000BBBB; write_collision=1 for exactly one cycle.
- Bypass: with BYPASS=1, read r12 while write0 0xDEADBEEF→r12 in the same cycle → read_data=0xDEADBEEF that cycle. With BYPASS=0 → the old value that cycle and 0xDEADBEEF the next.
- Zero register: write1 0xFFFFFFFF→r0 → r0 reads 0 on every port, both in the same cycle and afterwards.
- Mid-operation reset: write r3=0x12345678, assert reset_n for 1 cycle, release → ready=0 and the reads return 0. After 32 edges ready=1 and r3 reads 0. A write attempted during the clear is not stored.
